// File: rtl/rx_bit_sequencer.sv
// rx_bit_sequencer: programmable-rate UART receive sequencer (start wait, mid-bit strobes, stop check, buffer load).
// Optional start-bit validation enabled by defining RX_START_VALIDATE_EN.
module rx_bit_sequencer #(
    parameter int CNT_W     = 10,
    parameter int DATA_BITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] bit_period,
    input  logic             start_bit_detected,
    input  logic             serial_in,
    input  logic             framing_error,
    output logic             shift_strobe,
    output logic             sbc_clear,
    output logic             sbc_enable,
    output logic             load_buffer,
    output logic             busy,
    output logic             false_start
);
    localparam int BW = $clog2(DATA_BITS + 2);

    typedef enum logic [2:0] {IDLE, START_WAIT, RECV, STOP, EVAL, LOAD} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, period, period_n, half;
    logic [BW-1:0]    bits, bits_n;
    logic             fs_n;

    assign half = period >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            period <= '0;
            bits   <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            period <= period_n;
            bits   <= bits_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        period_n     = period;
        bits_n       = bits;
        fs_n         = 1'b0;
        shift_strobe = 1'b0;
        sbc_clear    = 1'b0;
        sbc_enable   = 1'b0;
        load_buffer  = 1'b0;
        case (state)
            IDLE: if (start_bit_detected) begin
                state_n  = START_WAIT;
                cnt_n    = '0;
                period_n = (bit_period < CNT_W'(4)) ? CNT_W'(4) : bit_period;
            end
            START_WAIT: begin
                sbc_clear = 1'b1;
                cnt_n     = cnt + 1'b1;
                if (cnt == half - 1'b1) begin
                    cnt_n  = '0;
                    bits_n = '0;
`ifdef RX_START_VALIDATE_EN
                    fs_n    = serial_in;
                    state_n = serial_in ? IDLE : RECV;
`else
                    state_n = RECV;
`endif
                end
            end
            RECV: begin
                cnt_n = cnt + 1'b1;
                if (cnt == period - 1'b1) begin
                    shift_strobe = 1'b1;
                    cnt_n        = '0;
                    bits_n       = bits + 1'b1;
                    // the strobe after the last data bit samples the stop bit
                    if (bits == BW'(DATA_BITS)) state_n = STOP;
                end
            end
            STOP: begin
                sbc_enable = 1'b1;
                state_n    = EVAL;
            end
            EVAL:    state_n = framing_error ? IDLE : LOAD;
            LOAD: begin
                load_buffer = 1'b1;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

`ifdef RX_START_VALIDATE_EN
    always_ff @(posedge clk) begin
        if (rst) false_start <= 1'b0;
        else     false_start <= fs_n;
    end
`else
    logic unused_in;
    assign unused_in   = serial_in ^ fs_n;
    assign false_start = 1'b0;
`endif
endmodule

// File: tb/tb_rx_bit_sequencer.sv
// tb_rx_bit_sequencer: directed plus randomized checks against a frame-timing reference model.
module tb_rx_bit_sequencer;
    localparam int CW = 10;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst, start_bit_detected, serial_in, framing_error;
    logic [CW-1:0] bit_period;
    logic          shift_strobe, sbc_clear, sbc_enable, load_buffer, busy, false_start;

    always #5 clk = ~clk;

    rx_bit_sequencer #(.CNT_W(CW), .DATA_BITS(DB)) dut (
        .clk(clk), .rst(rst), .bit_period(bit_period),
        .start_bit_detected(start_bit_detected), .serial_in(serial_in),
        .framing_error(framing_error), .shift_strobe(shift_strobe),
        .sbc_clear(sbc_clear), .sbc_enable(sbc_enable), .load_buffer(load_buffer),
        .busy(busy), .false_start(false_start)
    );

    int total = 0, bad = 0, cyc_n = 0;
    bit act = 0, fs_exp = 0;
    int s = 0, p = 4, h = 2;

    task automatic check(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0b want=%0b", tag, cyc_n, got, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs mid-cycle, then advance the model.
    task automatic tick(input bit r, input bit st, input int bp, input bit fe, input bit si);
        int t, last;
        bit fs_next;
        rst = r; start_bit_detected = st; bit_period = CW'(bp);
        framing_error = fe; serial_in = si;
        @(negedge clk);
        t    = cyc_n - s;
        last = h + (DB + 1) * p;
        check("busy", busy, act);
        check("sbc_clear", sbc_clear, act && t <= h);
        check("shift_strobe", shift_strobe, act && t > h && (t - h) % p == 0 && (t - h) / p <= DB + 1);
        check("sbc_enable", sbc_enable, act && t == last + 1);
        check("load_buffer", load_buffer, act && t == last + 3);
        check("false_start", false_start, fs_exp);
        fs_next = 0;
        if (r) act = 0;
        else if (act) begin
`ifdef RX_START_VALIDATE_EN
            if (t == h && si) begin act = 0; fs_next = 1; end
`endif
            if (t == last + 2 && fe) act = 0;
            if (t == last + 3) act = 0;
        end else if (st) begin
            act = 1; s = cyc_n; p = bp < 4 ? 4 : bp; h = p / 2;
        end
        fs_exp = fs_next;
        @(posedge clk); #1;
        cyc_n++;
    endtask

    initial begin
        rst = 1; start_bit_detected = 1; serial_in = 0; framing_error = 0; bit_period = 10;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++)   tick(1, 1, 10, 0, 0);
        for (int i = 0; i < 105; i++) tick(0, i == 0 || i == 40 || i == 98, 10, 0, 0);
        for (int i = 0; i < 105; i++) tick(0, i == 0, 10, i == 97, 0);
        for (int i = 0; i < 45; i++)  tick(0, i == 0, i < 3 ? 2 : 20, 0, 0);
        for (int i = 0; i < 60; i++)  tick(i == 50, i == 0 || i == 40, 10, 0, 0);
        for (int i = 0; i < 100; i++) tick(0, i == 0, 10, 0, i == 5);
        for (int i = 0; i < 100; i++) tick(0, i == 0, 10, 0, 0);
        for (int i = 0; i < 4000; i++)
            tick($urandom_range(0, 499) == 0, $urandom_range(0, 29) == 0,
                 int'($urandom_range(0, 12)), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
